// File: rtl/acc_pkg.sv
// Shared accumulator opcode constants.
// Used by the dispatcher and the accumulator controller.
package acc_pkg;

  localparam logic [2:0] OP_RESET   = 3'b000;
  localparam logic [2:0] OP_SHR     = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_INC     = 3'b011;
  localparam logic [2:0] OP_SWAP    = 3'b100;
  localparam logic [2:0] OP_CMPL    = 3'b101;
  localparam logic [2:0] OP_MULT    = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  function automatic logic is_legal(
    input logic [2:0] op
  );
    return op != OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous opcode FIFO with occupancy count.
// full/empty decode from the registered count.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok)
             - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/instr_dispatcher.sv
// Queues host opcodes and issues them one at a time
// to the accumulator controller over new_instruction/ready.
module instr_dispatcher #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [OP_W-1:0]        push_op,
  input  logic                   ready,
  output logic [OP_W-1:0]        instruction,
  output logic                   new_instruction,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   overflow,
  output logic                   bad_op
);
  import acc_pkg::*;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2
  } d_state_e;

  d_state_e        state_q, state_d;
  logic [OP_W-1:0] instr_q, instr_d;
  logic            ovf_q, ovf_d;
  logic            bad_q, bad_d;
  logic            push_ok, pop;
  logic [OP_W-1:0] head;

  // Accept uses registered full: a same-cycle pop frees nothing.
  assign push_ok = push && !full && is_legal(push_op);

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (OP_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (push_op),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pop     = 1'b0;
    ovf_d   = ovf_q | (push & full);
    bad_d   = bad_q | (push & ~is_legal(push_op));
    unique case (state_q)
      D_IDLE: begin
        if (!empty && ready) begin
          pop     = 1'b1;
          instr_d = head;
          state_d = D_ISSUE;
        end
      end
      D_ISSUE: begin
        if (ready)
          state_d = D_WAIT;
      end
      D_WAIT: begin
        if (ready && !empty) begin
          pop     = 1'b1;
          instr_d = head;
          state_d = D_ISSUE;
        end else if (ready) begin
          state_d = D_IDLE;
        end
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= D_IDLE;
      instr_q <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  assign instruction     = instr_q;
  assign new_instruction = state_q == D_ISSUE;
  assign busy            = !empty || state_q != D_IDLE;
  assign overflow        = ovf_q;
  assign bad_op          = bad_q;

endmodule
